// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM generator.
// All channels share one frame timebase (prescaler -> microsecond counter).
// Each channel holds a clamped target width and a live width. Once per frame
// the live width slews toward the target, so a pulse never changes mid-frame.
module servo_pwm_multi #(
  parameter int NUM_CH       = 4,
  parameter int CH_W         = 3,
  parameter int CLK_HZ       = 25_000_000,
  parameter int TICKS_PER_US = CLK_HZ / 1_000_000,
  parameter int PERIOD_US    = 20000,
  parameter int MIN_US       = 650,
  parameter int MAX_US       = 2600,
  parameter int CENTER_US    = (MIN_US + MAX_US) / 2,
  parameter int STEP_US      = 10,
  parameter int US_W         = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [11:0]       cmd_us,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] PMOD,
  output logic              frame_tick,
  output logic [NUM_CH-1:0] at_target,
  output logic              clamp_err,
  output logic              ch_err
);

  localparam int PS_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(TICKS_PER_US - 1);
  localparam logic [US_W-1:0] US_LAST  = US_W'(PERIOD_US - 1);
  localparam logic [US_W-1:0] CENTER_W = US_W'(CENTER_US);
  localparam logic [US_W-1:0] STEP_W   = US_W'(STEP_US);
  localparam logic [31:0]     MIN_U    = 32'(MIN_US);
  localparam logic [31:0]     MAX_U    = 32'(MAX_US);
  localparam logic [31:0]     NUM_CH_U = 32'(NUM_CH);

  logic [PS_W-1:0]   ps_q, ps_d;
  logic [US_W-1:0]   us_cnt_q, us_cnt_d;
  logic [US_W-1:0]   tgt_q [NUM_CH];
  logic [US_W-1:0]   tgt_d [NUM_CH];
  logic [US_W-1:0]   cur_q [NUM_CH];
  logic [US_W-1:0]   cur_d [NUM_CH];
  logic [NUM_CH-1:0] pmod_q, pmod_d;
  logic [NUM_CH-1:0] at_target_q, at_target_d;
  logic              cmd_ready_q;
  logic              clamp_err_q, clamp_err_d;
  logic              ch_err_q, ch_err_d;

  logic              cmd_fire;
  logic              cmd_ch_bad;
  logic              cmd_clamped;
  logic [31:0]       cmd_us_w;
  logic [US_W-1:0]   cmd_tgt;

  // Live width moves toward the target by at most STEP_US per frame;
  // a zero step means jump straight to the target.
  function automatic logic [US_W-1:0] slew_next(input logic [US_W-1:0] cur,
                                                 input logic [US_W-1:0] tgt);
    logic [US_W-1:0] nxt;
    nxt = tgt;
    if (STEP_US != 0) begin
      if (tgt > cur) begin
        if ((tgt - cur) > STEP_W) nxt = cur + STEP_W;
      end else if (cur > tgt) begin
        if ((cur - tgt) > STEP_W) nxt = cur - STEP_W;
      end
    end
    return nxt;
  endfunction

  // Shared timebase: prescaler wraps every microsecond, us counter every frame.
  always_comb begin
    ps_d     = ps_q + 1'b1;
    us_cnt_d = us_cnt_q;
    if (ps_q == PS_LAST) begin
      ps_d     = '0;
      us_cnt_d = (us_cnt_q == US_LAST) ? '0 : us_cnt_q + 1'b1;
    end
  end

  assign frame_tick = (ps_q == PS_LAST) && (us_cnt_q == US_LAST);

  // Command decode: range check and clamp are done on the full 12-bit request
  // so an oversize value cannot alias into range after truncation.
  always_comb begin
    cmd_fire    = cmd_valid && cmd_ready_q;
    cmd_us_w    = {20'd0, cmd_us};
    cmd_ch_bad  = ({{(32-CH_W){1'b0}}, cmd_ch} >= NUM_CH_U);
    cmd_clamped = 1'b0;
    cmd_tgt     = US_W'(cmd_us_w);
    if (cmd_us_w < MIN_U) begin
      cmd_clamped = 1'b1;
      cmd_tgt     = US_W'(MIN_U);
    end else if (cmd_us_w > MAX_U) begin
      cmd_clamped = 1'b1;
      cmd_tgt     = US_W'(MAX_U);
    end
    clamp_err_d = cmd_fire && !cmd_ch_bad && cmd_clamped;
    ch_err_d    = cmd_fire && cmd_ch_bad;
  end

  // Per-channel target write, frame slew, output compare and at-target flag.
  // Slew reads the old target, so a write landing on frame_tick waits a frame.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_d[i] = tgt_q[i];
      cur_d[i] = cur_q[i];
      if (cmd_fire && !cmd_ch_bad && (cmd_ch == CH_W'(i))) tgt_d[i] = cmd_tgt;
      if (frame_tick) cur_d[i] = slew_next(cur_q[i], tgt_q[i]);
      pmod_d[i]      = ch_en[i] && (us_cnt_q < cur_q[i]);
      at_target_d[i] = (cur_q[i] == tgt_q[i]);
    end
  end

  // State registers; reset forces outputs low immediately and centres servos.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ps_q        <= '0;
      us_cnt_q    <= '0;
      pmod_q      <= '0;
      at_target_q <= '1;
      cmd_ready_q <= 1'b0;
      clamp_err_q <= 1'b0;
      ch_err_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= CENTER_W;
        cur_q[i] <= CENTER_W;
      end
    end else begin
      ps_q        <= ps_d;
      us_cnt_q    <= us_cnt_d;
      pmod_q      <= pmod_d;
      at_target_q <= at_target_d;
      cmd_ready_q <= 1'b1;
      clamp_err_q <= clamp_err_d;
      ch_err_q    <= ch_err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        tgt_q[i] <= tgt_d[i];
        cur_q[i] <= cur_d[i];
      end
    end
  end

  assign PMOD      = pmod_q;
  assign at_target = at_target_q;
  assign cmd_ready = cmd_ready_q;
  assign clamp_err = clamp_err_q;
  assign ch_err    = ch_err_q;

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Parametrised multi-channel hobby-servo PWM generator; successor to the single-channel SG90 driver. All channels share one frame timebase (default 20 ms). Each channel has a µs-resolution target written over a valid/ready command port, with clamping to safe limits. A per-frame slew limiter moves the live pulse width toward its target. Sits between the arm motion controller and the PMOD servo pins.

Parameters:
NUM_CH, 4, number of servo channels (1..8)
CH_W, 3, width of cmd_ch; 2**CH_W >= NUM_CH
CLK_HZ, 25000000, input clock frequency
TICKS_PER_US, CLK_HZ/1000000 (25), clocks per microsecond
PERIOD_US, 20000, frame period in µs
MIN_US, 650, minimum pulse width (0 deg)
MAX_US, 2600, maximum pulse width (180 deg)
CENTER_US, (MIN_US+MAX_US)/2 (1625), reset pulse width
STEP_US, 10, maximum change of live width per frame; 0 = no slew limit
US_W, 15, width of µs counters/registers; must hold PERIOD_US-1

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command port can accept
cmd_ch  in  CH_W  target channel index
cmd_us  in  12  requested pulse width, µs
ch_en  in  NUM_CH  per-channel output enable
PMOD  out  NUM_CH  servo PWM outputs
frame_tick  out  1  one-cycle pulse on the last clock of each frame
at_target  out  NUM_CH  live width == target, per channel
clamp_err  out  1  one-cycle pulse: accepted command was clamped
ch_err  out  1  one-cycle pulse: accepted command had cmd_ch >= NUM_CH

Behaviour:
- Reset (RST_N low, async): PMOD=0, cmd_ready=0, frame_tick=0, clamp_err=0, ch_err=0; prescaler=0, us_cnt=0; every tgt[i]=cur[i]=CENTER_US; at_target=all ones. Reset mid-pulse drops PMOD immediately.
- cmd_ready registered: 1 from the first clock edge after RST_N release, then constantly 1.
- Timebase: prescaler counts 0..TICKS_PER_US-1; at terminal value it wraps and us_cnt increments, wrapping PERIOD_US-1 -> 0. Frame = PERIOD_US*TICKS_PER_US clocks (500000).
- frame_tick is combinational from the counters: high when prescaler==TICKS_PER_US-1 and us_cnt==PERIOD_US-1.
- Output: PMOD[i] is registered as ch_en[i] && (us_cnt < cur[i]). One-clock latency from the counters. High time is exactly cur[i]*TICKS_PER_US clocks. Disabling a channel forces its output low on the next clock; slewing continues while disabled.
- Command accept: a command is accepted when cmd_valid && cmd_ready.
  - If cmd_ch >= NUM_CH: no register changes; ch_err pulses on the next cycle.
  - Otherwise tgt[cmd_ch] <= clamp(cmd_us, MIN_US, MAX_US). If clamping applied, clamp_err pulses on the next cycle.
  - Back-to-back commands, including to the same channel, are allowed; the last write wins.
- Slew, on frame_tick, for each i:
  - If STEP_US==0 or |tgt-cur| <= STEP_US: cur <= tgt.
  - Else cur <= cur ± STEP_US toward tgt.
  - The new cur takes effect from us_cnt=0 of the next frame, so pulse width never changes mid-frame.
- Simultaneous command and frame_tick on the same channel: the slew step uses the old tgt. The new tgt is written the same edge and is used from the next frame_tick.
- at_target[i] is registered (cur[i]==tgt[i]) and updates one cycle after any change.
- Arithmetic is unsigned; compare cmd_us against the limits before truncating to US_W.

Test Plan:
1. Reset then release, all ch_en=1 -> cmd_ready=1 after one clock. Each PMOD goes high at frame start for 40625 clocks. Period is 500000 clocks. frame_tick fires once per 500000 clocks.
2. cmd ch1 = 1645 -> ch1 high 40625 clocks in the current frame, then 40875 (1635 µs), then 41125 (1645 µs). at_target[1] is 0 after the write and returns to 1 one cycle after the second frame_tick.
3. cmd ch2 = 100 -> tgt 650 with a clamp_err pulse. cmd ch3 = 4000 -> tgt 2600 with a clamp_err pulse. Widths step by 10 µs per frame toward the limit and never exceed it.
4. cmd_ch = 5 with NUM_CH=4 -> ch_err pulses for one cycle. No tgt changes, no clamp_err, and all PMOD widths are unchanged.
5. cmd ch0 = 2000 asserted exactly on the frame_tick cycle -> the next frame stays at 1625 µs (no step). The following frame is 1635 µs.
6. Drop RST_N mid-pulse with ch0 at 2000 µs -> PMOD=0 immediately. After release, ch0 restarts at 1625 µs. Drop ch_en[0] mid-pulse -> PMOD[0] goes low the next clock.
